// File: rtl/hopfield_sequencer.sv
// hopfield_sequencer: learn/recall sequencer for hopfield_network; define HOPFIELD_SEQ_ACTIVITY_EN to drive activity with popcount(result)
module hopfield_sequencer #(
    parameter int NUM_PAT       = 4,
    parameter int LEARN_CYCLES  = 8,
    parameter int EPOCHS        = 2,
    parameter int CUE_CYCLES    = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int MAX_ITER      = 64,
    localparam int AW           = $clog2(NUM_PAT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_wr,
    input  logic [AW-1:0] cfg_addr,
    input  logic [3:0]    cfg_data,
    input  logic [AW:0]   cfg_count,
    input  logic          start_learn,
    input  logic          start_recall,
    input  logic [3:0]    cue,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic [6:0]    result,
    output logic [7:0]    iter_count,
    output logic          net_learning_enable,
    output logic [3:0]    net_pattern,
    input  logic [6:0]    net_spikes,
    output logic [2:0]    activity
);
    typedef enum logic [2:0] {IDLE, LEARN, CUE, SETTLE, DONE} state_t;
    state_t        state_q, state_d;
    logic [3:0]    buf_q [NUM_PAT];
    logic [3:0]    buf_d [NUM_PAT];
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   n_q, n_d;
    logic [7:0]    cnt_q, cnt_d, epoch_q, epoch_d, iter_q, iter_d, stable_q, stable_d;
    logic [6:0]    prev_q, prev_d, result_q, result_d;
    logic [3:0]    cue_q, cue_d, pat_q, pat_d;
    logic [2:0]    act_q, act_d;
    logic          conv_q, conv_d, busy_q, busy_d, done_q, done_d, le_q, le_d;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        epoch_d  = epoch_q;
        iter_d   = iter_q;
        stable_d = stable_q;
        prev_d   = prev_q;
        result_d = result_q;
        cue_d    = cue_q;
        conv_d   = conv_q;
        case (state_q)
            IDLE: begin
                if (cfg_wr) buf_d[cfg_addr] = cfg_data;
                if (start_learn) begin
                    n_d     = (cfg_count > (AW+1)'(NUM_PAT)) ? (AW+1)'(NUM_PAT) : cfg_count;
                    idx_d   = '0;
                    epoch_d = '0;
                    cnt_d   = '0;
                    conv_d  = 1'b0;
                    state_d = (cfg_count == '0) ? DONE : LEARN;
                end else if (start_recall) begin
                    cue_d    = cue;
                    conv_d   = 1'b0;
                    iter_d   = '0;
                    stable_d = '0;
                    cnt_d    = '0;
                    state_d  = CUE;
                end
            end
            LEARN: begin
                cnt_d = (cnt_q == 8'(LEARN_CYCLES-1)) ? 8'd0 : cnt_q + 8'd1;
                if (cnt_q == 8'(LEARN_CYCLES-1)) begin
                    idx_d = ({1'b0, idx_q} == n_q - 1'b1) ? '0 : idx_q + 1'b1;
                    if ({1'b0, idx_q} == n_q - 1'b1) begin
                        epoch_d = epoch_q + 8'd1;
                        if (epoch_q == 8'(EPOCHS-1)) state_d = DONE;
                    end
                end
            end
            CUE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(CUE_CYCLES-1)) begin
                    cnt_d   = '0;
                    prev_d  = net_spikes;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                iter_d   = iter_q + 8'd1;
                stable_d = (net_spikes == prev_q) ? stable_q + 8'd1 : 8'd0;
                prev_d   = net_spikes;
                if (stable_d == 8'(STABLE_CYCLES) || iter_d == 8'(MAX_ITER)) begin
                    conv_d   = (stable_d == 8'(STABLE_CYCLES));
                    result_d = net_spikes;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        le_d   = (state_d == LEARN);
        pat_d  = (state_d == LEARN) ? buf_q[idx_d] : (state_d == CUE) ? cue_d : 4'h0;
`ifdef HOPFIELD_SEQ_ACTIVITY_EN
        act_d  = 3'($countones(result_d));
`else
        act_d  = 3'b000;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            buf_q    <= '{default: '0};
            idx_q    <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            epoch_q  <= '0;
            iter_q   <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            result_q <= '0;
            cue_q    <= '0;
            conv_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            le_q     <= 1'b0;
            pat_q    <= '0;
            act_q    <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            epoch_q  <= epoch_d;
            iter_q   <= iter_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            result_q <= result_d;
            cue_q    <= cue_d;
            conv_q   <= conv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            le_q     <= le_d;
            pat_q    <= pat_d;
            act_q    <= act_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign converged           = conv_q;
    assign result              = result_q;
    assign iter_count          = iter_q;
    assign net_learning_enable = le_q;
    assign net_pattern         = pat_q;
    assign activity            = act_q;
endmodule

// File: tb/tb_hopfield_sequencer.sv
// tb_hopfield_sequencer: directed scenario tasks for hopfield_sequencer
module tb_hopfield_sequencer;
    logic       clk = 0, rst_n = 0, cfg_wr = 0, start_learn = 0, start_recall = 0;
    logic [1:0] cfg_addr = 0;
    logic [3:0] cfg_data = 0, cue = 0;
    logic [2:0] cfg_count = 0;
    logic [6:0] net_spikes = 0;
    logic       busy, done, converged, net_learning_enable;
    logic [6:0] result;
    logic [7:0] iter_count;
    logic [3:0] net_pattern;
    logic [2:0] activity;
    int errors = 0, checks = 0;

    hopfield_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_count(cfg_count), .start_learn(start_learn), .start_recall(start_recall), .cue(cue),
        .busy(busy), .done(done), .converged(converged), .result(result), .iter_count(iter_count),
        .net_learning_enable(net_learning_enable), .net_pattern(net_pattern),
        .net_spikes(net_spikes), .activity(activity)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        cfg_addr = a;
        cfg_data = d;
        cfg_wr   = 1;
        tick;
        cfg_wr   = 0;
    endtask

    task automatic wait_done(input string name, input int budget, input int exp_k);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick;
            k++;
        end
        checks++;
        if (done !== 1'b1 || k != exp_k) begin
            errors++;
            $display("FAIL %s: done=%b after %0d cycles, required done=1 after %0d", name, done, k, exp_k);
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick;
        tick;
        checks++;
        if ({busy, done, converged, net_learning_enable} !== 4'b0 || result !== 0 || iter_count !== 0 ||
            net_pattern !== 0 || activity !== 0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b conv=%b le=%b result=%h iter=%0d pat=%h act=%0d, required all 0",
                     busy, done, converged, net_learning_enable, result, iter_count, net_pattern, activity);
        end
        rst_n = 1;
        wr(0, 4'h5);
        cfg_count = 1;
        start_learn = 1;
        tick;
        start_learn = 0;
        checks++;
        if (net_learning_enable !== 1'b1 || net_pattern !== 4'h5) begin
            errors++;
            $display("FAIL pre_reset_learn: le=%b pat=%h, required le=1 pat=5", net_learning_enable, net_pattern);
        end
        tick;
        tick;
        rst_n = 0;
        tick;
        rst_n = 1;
        checks++;
        if (busy !== 0 || net_learning_enable !== 0 || done !== 0 || net_pattern !== 0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b le=%b done=%b pat=%h, required all 0",
                     busy, net_learning_enable, done, net_pattern);
        end
        start_learn = 1;
        tick;
        start_learn = 0;
        checks++;
        if (net_learning_enable !== 1'b1 || net_pattern !== 4'h0) begin
            errors++;
            $display("FAIL reset_buffer_clear: le=%b pat=%h, required le=1 pat=0", net_learning_enable, net_pattern);
        end
        wait_done("reset_learn_len", 100, 16);
    endtask

    task automatic test_learn;
        logic [3:0] exp;
        wr(0, 4'hA);
        wr(1, 4'h5);
        cfg_count = 2;
        start_learn = 1;
        tick;
        start_learn = 0;
        for (int i = 0; i < 32; i++) begin
            exp = ((i / 8) % 2 == 1) ? 4'h5 : 4'hA;
            checks++;
            if ({busy, net_learning_enable, done} !== 3'b110 || net_pattern !== exp) begin
                errors++;
                $display("FAIL learn_cycle%0d: busy/le/done=%b pat=%h, required 110 pat=%h",
                         i, {busy, net_learning_enable, done}, net_pattern, exp);
            end
            tick;
        end
        checks++;
        if (done !== 1 || busy !== 1 || net_learning_enable !== 0 || net_pattern !== 0) begin
            errors++;
            $display("FAIL learn_done: done=%b busy=%b le=%b pat=%h, required 1 1 0 0",
                     done, busy, net_learning_enable, net_pattern);
        end
        tick;
        checks++;
        if (done !== 0 || busy !== 0 || result !== 0) begin
            errors++;
            $display("FAIL learn_idle: done=%b busy=%b result=%h, required 0 0 00", done, busy, result);
        end
    endtask

    task automatic test_recall_converge;
        logic [2:0] exp_act;
`ifdef HOPFIELD_SEQ_ACTIVITY_EN
        exp_act = 3'd3;
`else
        exp_act = 3'd0;
`endif
        net_spikes = 7'h15;
        cue = 4'h3;
        start_recall = 1;
        tick;
        start_recall = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1 || net_learning_enable !== 0 || net_pattern !== 4'h3 || done !== 0) begin
                errors++;
                $display("FAIL cue_cycle%0d: busy=%b le=%b pat=%h done=%b, required 1 0 3 0",
                         i, busy, net_learning_enable, net_pattern, done);
            end
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1 || net_pattern !== 4'h0 || done !== 0) begin
                errors++;
                $display("FAIL settle_cycle%0d: busy=%b pat=%h done=%b, required 1 0 0", i, busy, net_pattern, done);
            end
            tick;
        end
        checks++;
        if (done !== 1 || converged !== 1 || iter_count !== 8'd3 || result !== 7'h15) begin
            errors++;
            $display("FAIL recall_done: done=%b conv=%b iter=%0d result=%h, required 1 1 3 15",
                     done, converged, iter_count, result);
        end
        checks++;
        if (activity !== exp_act) begin
            errors++;
            $display("FAIL activity: got %0d, required %0d", activity, exp_act);
        end
        tick;
        checks++;
        if (done !== 0 || busy !== 0 || converged !== 1) begin
            errors++;
            $display("FAIL converged_hold: done=%b busy=%b conv=%b, required 0 0 1", done, busy, converged);
        end
    endtask

    task automatic test_recall_timeout;
        int k;
        logic [6:0] s;
        cue = 4'h9;
        start_recall = 1;
        tick;
        start_recall = 0;
        checks++;
        if (converged !== 0 || iter_count !== 0 || net_pattern !== 4'h9) begin
            errors++;
            $display("FAIL recall_clear: conv=%b iter=%0d pat=%h, required 0 0 9", converged, iter_count, net_pattern);
        end
        k = 0;
        s = net_spikes;
        while (!done && k < 200) begin
            net_spikes = ~net_spikes;
            s = net_spikes;
            tick;
            k++;
        end
        checks++;
        if (done !== 1 || k != 68) begin
            errors++;
            $display("FAIL timeout_length: done=%b after %0d cycles, required done=1 after 68", done, k);
        end
        checks++;
        if (converged !== 0 || iter_count !== 8'd64 || result !== s) begin
            errors++;
            $display("FAIL timeout_result: conv=%b iter=%0d result=%h, required 0 64 %h", converged, iter_count, result, s);
        end
        net_spikes = 7'h15;
        tick;
    endtask

    task automatic test_priority_protect;
        cfg_count = 1;
        cue = 4'hF;
        start_learn = 1;
        start_recall = 1;
        tick;
        start_learn = 0;
        start_recall = 0;
        checks++;
        if (net_learning_enable !== 1 || net_pattern !== 4'hA) begin
            errors++;
            $display("FAIL learn_priority: le=%b pat=%h, required le=1 pat=a", net_learning_enable, net_pattern);
        end
        wr(0, 4'hC);
        wait_done("priority_learn_len", 100, 15);
        start_learn = 1;
        tick;
        start_learn = 0;
        checks++;
        if (net_pattern !== 4'hA) begin
            errors++;
            $display("FAIL write_protect: pat=%h, required a", net_pattern);
        end
        wait_done("protect_learn_len", 100, 16);
    endtask

    task automatic test_zero_count;
        cfg_count = 0;
        start_learn = 1;
        tick;
        start_learn = 0;
        checks++;
        if (done !== 1 || busy !== 1 || net_learning_enable !== 0) begin
            errors++;
            $display("FAIL zero_count_done: done=%b busy=%b le=%b, required 1 1 0", done, busy, net_learning_enable);
        end
        tick;
        checks++;
        if (done !== 0 || busy !== 0 || net_learning_enable !== 0) begin
            errors++;
            $display("FAIL zero_count_idle: done=%b busy=%b le=%b, required 0 0 0", done, busy, net_learning_enable);
        end
    endtask

    task automatic test_back_to_back;
        cfg_count = 0;
        start_learn = 1;
        tick;
        checks++;
        if (done !== 1) begin
            errors++;
            $display("FAIL b2b_first: done=%b, required 1", done);
        end
        tick;
        checks++;
        if (done !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL b2b_gap: done=%b busy=%b, required 0 0", done, busy);
        end
        tick;
        checks++;
        if (done !== 1) begin
            errors++;
            $display("FAIL b2b_second: done=%b, required 1", done);
        end
        start_learn = 0;
        tick;
    endtask

    task automatic test_clamp;
        int k;
        logic [3:0] p;
        wr(2, 4'h7);
        wr(3, 4'h9);
        cfg_count = 7;
        start_learn = 1;
        tick;
        start_learn = 0;
        k = 0;
        p = 0;
        while (!done && k < 200) begin
            if (k == 24) p = net_pattern;
            tick;
            k++;
        end
        checks++;
        if (done !== 1 || k != 64) begin
            errors++;
            $display("FAIL clamp_length: done=%b after %0d cycles, required done=1 after 64", done, k);
        end
        checks++;
        if (p !== 4'h9) begin
            errors++;
            $display("FAIL clamp_pattern: pat=%h at cycle 24, required 9", p);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_learn;
        test_recall_converge;
        test_recall_timeout;
        test_priority_protect;
        test_zero_count;
        test_back_to_back;
        test_clamp;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
